// File: rtl/multicycle_control_if.sv
// multicycle_control_if: datapath-facing signals of the multi-cycle controller.
interface multicycle_control_if #(parameter int CNT_W = 16);
  logic [5:0] opcode;
  logic zero, mem_ready;
  logic pc_write, pc_write_cond, pc_en, i_or_d, mem_read, mem_write, ir_write;
  logic mem_to_reg, reg_dst, reg_write, alu_src_a;
  logic [1:0] alu_src_b, alu_op, pc_source;
  logic [3:0] state;
  logic illegal_op;
  logic [CNT_W-1:0] retired;
  modport master (
    input opcode, zero, mem_ready,
    output pc_write, pc_write_cond, pc_en, i_or_d, mem_read, mem_write, ir_write,
    output mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op, pc_source,
    output state, illegal_op, retired
  );
  modport slave (
    output opcode, zero, mem_ready,
    input pc_write, pc_write_cond, pc_en, i_or_d, mem_read, mem_write, ir_write,
    input mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op, pc_source,
    input state, illegal_op, retired
  );
endinterface

// File: rtl/multicycle_control.sv
// multicycle_control: multi-cycle MIPS-style control FSM with a retired-instruction counter.
module multicycle_control #(parameter int CNT_W = 16) (
  input logic clk,
  input logic rst_n,
  multicycle_control_if.master bus
);
  typedef enum logic [3:0] {
    FETCH = 4'd0, DECODE = 4'd1, MEM_ADDR = 4'd2, MEM_READ = 4'd3, MEM_WB = 4'd4,
    MEM_WRITE = 4'd5, R_EXEC = 4'd6, R_WB = 4'd7, BRANCH = 4'd8, JUMP = 4'd9
  } state_t;
  localparam logic [5:0] OP_R = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011;
  localparam logic [5:0] OP_BEQ = 6'b000100, OP_J = 6'b000010;
  state_t st, nxt;
  logic [CNT_W-1:0] cnt;
  logic is_r, is_lw, is_sw, is_beq, is_j, retire;
  logic pw, pwc, iod, mrd, mwr, irw, m2r, rd, rw, asa, ill;
  logic [1:0] asb, aop, psrc;
  assign is_r = bus.opcode == OP_R;
  assign is_lw = bus.opcode == OP_LW;
  assign is_sw = bus.opcode == OP_SW;
  assign is_beq = bus.opcode == OP_BEQ;
  assign is_j = bus.opcode == OP_J;
  // MEM_WRITE only retires on the cycle the store actually completes
  assign retire = (st inside {MEM_WB, R_WB, BRANCH, JUMP}) || (st == MEM_WRITE && bus.mem_ready);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      st <= FETCH;
      cnt <= '0;
    end else begin
      st <= nxt;
      if (retire) cnt <= cnt + 1'b1;
    end
  always_comb begin
    nxt = FETCH;
    {pw, pwc, iod, mrd, mwr, irw, m2r, rd, rw, asa, ill} = '0;
    asb = 2'b00;
    aop = 2'b00;
    psrc = 2'b00;
    case (st)
      FETCH: begin
        nxt = bus.mem_ready ? DECODE : FETCH;
        mrd = 1'b1;
        asb = 2'b01;
        irw = bus.mem_ready;
        pw = bus.mem_ready;
      end
      DECODE: begin
        nxt = (is_lw || is_sw) ? MEM_ADDR : is_r ? R_EXEC : is_beq ? BRANCH : is_j ? JUMP : FETCH;
        asb = 2'b11;
        ill = !(is_lw || is_sw || is_r || is_beq || is_j);
      end
      MEM_ADDR: begin
        nxt = is_lw ? MEM_READ : MEM_WRITE;
        asa = 1'b1;
        asb = 2'b10;
      end
      MEM_READ: begin
        nxt = bus.mem_ready ? MEM_WB : MEM_READ;
        mrd = 1'b1;
        iod = 1'b1;
      end
      MEM_WB: {rw, m2r} = 2'b11;
      MEM_WRITE: begin
        nxt = bus.mem_ready ? FETCH : MEM_WRITE;
        mwr = 1'b1;
        iod = 1'b1;
      end
      R_EXEC: begin
        nxt = R_WB;
        asa = 1'b1;
        aop = 2'b10;
      end
      R_WB: {rw, rd} = 2'b11;
      BRANCH: begin
        asa = 1'b1;
        aop = 2'b01;
        pwc = 1'b1;
        psrc = 2'b01;
      end
      JUMP: begin
        pw = 1'b1;
        psrc = 2'b10;
      end
      default: nxt = FETCH;
    endcase
  end
  assign bus.pc_write = pw;
  assign bus.pc_write_cond = pwc;
  assign bus.pc_en = pw | (pwc & bus.zero);
  assign bus.i_or_d = iod;
  assign bus.mem_read = mrd;
  assign bus.mem_write = mwr;
  assign bus.ir_write = irw;
  assign bus.mem_to_reg = m2r;
  assign bus.reg_dst = rd;
  assign bus.reg_write = rw;
  assign bus.alu_src_a = asa;
  assign bus.alu_src_b = asb;
  assign bus.alu_op = aop;
  assign bus.pc_source = psrc;
  assign bus.state = st;
  assign bus.illegal_op = ill;
  assign bus.retired = cnt;
endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control: vector table, corner sequences and random instruction streams for the controller.
module tb_multicycle_control;
  localparam int W = 4;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  multicycle_control_if #(.CNT_W(W)) bus();
  multicycle_control #(.CNT_W(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  typedef struct {int st; logic mr;} step_t;
  typedef struct {logic [5:0] op; logic z; int fw; int mw; logic pc_en; int inc;} vec_t;
  int total = 0, bad = 0, exp_ret = 0;
  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got 'h%0h expected 'h%0h at %0t", name, act, exp, $time);
    end
  endtask
  function automatic logic legal(input logic [5:0] op);
    return op inside {6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000010};
  endfunction
  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction
  function automatic logic [17:0] obs();
    return {bus.pc_write, bus.pc_write_cond, bus.pc_en, bus.i_or_d, bus.mem_read, bus.mem_write,
            bus.ir_write, bus.mem_to_reg, bus.reg_dst, bus.reg_write, bus.alu_src_a,
            bus.alu_src_b, bus.alu_op, bus.pc_source, bus.illegal_op};
  endfunction
  // Control outputs listed per state in the datapath control table; everything else is 0
  function automatic logic [17:0] exp_outs(input int st, input logic mr, input logic [5:0] op, input logic z);
    logic pw, pwc, iod, mrd, mwr, irw, m2r, rd, rw, asa, ill;
    logic [1:0] asb, aop, psrc;
    {pw, pwc, iod, mrd, mwr, irw, m2r, rd, rw, asa, ill} = '0;
    asb = 2'b00;
    aop = 2'b00;
    psrc = 2'b00;
    case (st)
      0: begin mrd = 1'b1; asb = 2'b01; irw = mr; pw = mr; end
      1: begin asb = 2'b11; ill = !legal(op); end
      2: begin asa = 1'b1; asb = 2'b10; end
      3: begin mrd = 1'b1; iod = 1'b1; end
      4: begin rw = 1'b1; m2r = 1'b1; end
      5: begin mwr = 1'b1; iod = 1'b1; end
      6: begin asa = 1'b1; aop = 2'b10; end
      7: begin rw = 1'b1; rd = 1'b1; end
      8: begin asa = 1'b1; aop = 2'b01; pwc = 1'b1; psrc = 2'b01; end
      9: begin pw = 1'b1; psrc = 2'b10; end
      default: ;
    endcase
    return {pw, pwc, pw | (pwc & z), iod, mrd, mwr, irw, m2r, rd, rw, asa, asb, aop, psrc, ill};
  endfunction
  // Builds the instruction's state path (with memory waits) and walks it one cycle per step
  task automatic run_instr(input logic [5:0] op, input logic z, input int fw, input int mw,
                           output logic last_pc_en, output int inc);
    step_t q[$];
    int r0;
    r0 = int'(bus.retired);
    last_pc_en = 1'b0;
    for (int i = 0; i < fw; i++) q.push_back('{0, 1'b0});
    q.push_back('{0, 1'b1});
    q.push_back('{1, rb()});
    if (op == 6'b100011) begin
      q.push_back('{2, rb()});
      for (int i = 0; i < mw; i++) q.push_back('{3, 1'b0});
      q.push_back('{3, 1'b1});
      q.push_back('{4, rb()});
    end else if (op == 6'b101011) begin
      q.push_back('{2, rb()});
      for (int i = 0; i < mw; i++) q.push_back('{5, 1'b0});
      q.push_back('{5, 1'b1});
    end else if (op == 6'b000000) begin
      q.push_back('{6, rb()});
      q.push_back('{7, rb()});
    end else if (op == 6'b000100) q.push_back('{8, rb()});
    else if (op == 6'b000010) q.push_back('{9, rb()});
    bus.opcode = op;
    bus.zero = z;
    foreach (q[i]) begin
      bus.mem_ready = q[i].mr;
      @(negedge clk);
      chk($sformatf("state op=%0h step=%0d", op, i), int'(bus.state), q[i].st);
      chk($sformatf("outs op=%0h st=%0d", op, q[i].st), int'(obs()), int'(exp_outs(q[i].st, q[i].mr, op, z)));
      last_pc_en = bus.pc_en;
      @(posedge clk);
      #1;
    end
    if (legal(op)) exp_ret = (exp_ret + 1) % (1 << W);
    chk($sformatf("retired op=%0h", op), int'(bus.retired), exp_ret);
    inc = (int'(bus.retired) - r0) & ((1 << W) - 1);
  endtask
  initial begin
    vec_t tbl[8];
    logic pe;
    int inc;
    logic [5:0] op;
    tbl[0] = '{6'b100011, 1'b0, 0, 0, 1'b0, 1};
    tbl[1] = '{6'b101011, 1'b0, 1, 3, 1'b0, 1};
    tbl[2] = '{6'b000100, 1'b1, 0, 0, 1'b1, 1};
    tbl[3] = '{6'b000100, 1'b0, 0, 0, 1'b0, 1};
    tbl[4] = '{6'b000000, 1'b0, 0, 0, 1'b0, 1};
    tbl[5] = '{6'b000010, 1'b0, 2, 0, 1'b1, 1};
    tbl[6] = '{6'b111111, 1'b0, 0, 0, 1'b0, 0};
    tbl[7] = '{6'b100011, 1'b1, 2, 2, 1'b0, 1};
    bus.opcode = '0;
    bus.zero = 1'b0;
    bus.mem_ready = 1'b0;
    #12;
    chk("rst_state", int'(bus.state), 0);
    chk("rst_retired", int'(bus.retired), 0);
    chk("rst_outs", int'(obs()), int'(exp_outs(0, 1'b0, 6'd0, 1'b0)));
    bus.mem_ready = 1'b1;
    #1;
    chk("rst_outs_ready", int'(obs()), int'(exp_outs(0, 1'b1, 6'd0, 1'b0)));
    bus.mem_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_state", int'(bus.state), 0);
    foreach (tbl[i]) begin
      run_instr(tbl[i].op, tbl[i].z, tbl[i].fw, tbl[i].mw, pe, inc);
      chk($sformatf("vec%0d_pc_en", i), int'(pe), int'(tbl[i].pc_en));
      chk($sformatf("vec%0d_inc", i), inc, tbl[i].inc);
    end
    for (int n = 0; n < 40; n++) begin
      case ($urandom_range(0, 5))
        0: op = 6'b000000;
        1: op = 6'b100011;
        2: op = 6'b101011;
        3: op = 6'b000100;
        4: op = 6'b000010;
        default: op = 6'($urandom);
      endcase
      run_instr(op, rb(), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), pe, inc);
    end
    run_instr(6'b000010, 1'b0, 0, 0, pe, inc);
    bus.opcode = 6'b100011;
    bus.mem_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    bus.mem_ready = 1'b0;
    @(posedge clk);
    #1;
    chk("pre_rst_memread", int'(bus.state), 3);
    #2 rst_n = 1'b0;
    #1;
    exp_ret = 0;
    chk("midrst_state", int'(bus.state), 0);
    chk("midrst_retired", int'(bus.retired), 0);
    chk("midrst_outs", int'(obs()), int'(exp_outs(0, 1'b0, 6'b100011, 1'b0)));
    #1 rst_n = 1'b1;
    bus.opcode = 6'b111111;
    bus.mem_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("rel_decode", int'(bus.state), 1);
    chk("rel_illegal", int'(bus.illegal_op), 1);
    @(posedge clk);
    #1;
    chk("rel_fetch", int'(bus.state), 0);
    chk("rel_retired", int'(bus.retired), 0);
    repeat (15) run_instr(6'b000010, 1'b0, 0, 0, pe, inc);
    chk("preload_15", int'(bus.retired), 15);
    run_instr(6'b000010, 1'b0, 0, 0, pe, inc);
    chk("wrap_to_0", int'(bus.retired), 0);
    repeat (15) run_instr(6'b000010, 1'b0, 0, 0, pe, inc);
    chk("wrap_back_15", int'(bus.retired), 15);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 SHALL have parameter CNT_W, default 16, the width of the retired-instruction counter.
REQ-002 SHALL have port clk  in  1  single clock; all state changes on the rising edge.
REQ-003 SHALL have port rst_n  in  1  reset, asynchronous and active-low.
REQ-004 SHALL have port opcode  in  6  instruction register bits [31:26], stable from DECODE onward.
REQ-005 SHALL have port zero  in  1  ALU zero flag.
REQ-006 SHALL have port mem_ready  in  1  memory access completes this cycle.
REQ-007 SHALL have ports pc_write, pc_write_cond, pc_en, i_or_d, mem_read, mem_write, ir_write, mem_to_reg, reg_dst, reg_write, alu_src_a  out  1 each, with standard multi-cycle datapath meanings.
REQ-008 SHALL have ports alu_src_b, alu_op, pc_source  out  2 each; alu_op feeds alu_control (00 add, 01 sub, 10 use func).
REQ-009 SHALL have port state  out  4  current state code; illegal_op  out  1; retired  out  CNT_W  retired-instruction count.

Function
REQ-010 SHALL implement a state register with encodings FETCH=0, DECODE=1, MEM_ADDR=2, MEM_READ=3, MEM_WB=4, MEM_WRITE=5, R_EXEC=6, R_WB=7, BRANCH=8, JUMP=9; codes 10-15 SHALL go to FETCH on the next edge.
REQ-011 SHALL decode the supported opcodes as follows: 000000 R-type, 100011 lw, 101011 sw, 000100 beq, 000010 j; all other opcodes are illegal.
REQ-012 SHALL make the following transitions:
  - FETCH->DECODE when mem_ready=1, else stay in FETCH.
  - DECODE->MEM_ADDR on lw/sw, R_EXEC on R-type, BRANCH on beq, JUMP on j, FETCH on an illegal opcode.
  - MEM_ADDR->MEM_READ on lw, MEM_WRITE on sw.
  - MEM_READ->MEM_WB when mem_ready=1, else stay in MEM_READ.
  - MEM_WRITE->FETCH when mem_ready=1, else stay in MEM_WRITE.
  - R_EXEC->R_WB; MEM_WB, R_WB, BRANCH and JUMP->FETCH.
REQ-013 SHALL drive every control output to 0 unless it is listed for the current state below; outputs SHALL be combinational from state, mem_ready, opcode and zero.
REQ-014 SHALL, in FETCH, drive mem_read=1, alu_src_b=01, alu_op=00, pc_source=00, and ir_write=pc_write=mem_ready.
REQ-015 SHALL, in DECODE, drive alu_src_b=11 and alu_op=00 (branch target precompute); illegal_op=1 only in DECODE with an illegal opcode.
REQ-016 SHALL, in MEM_ADDR, drive alu_src_a=1, alu_src_b=10, alu_op=00.
REQ-017 SHALL, in MEM_READ, drive mem_read=1 and i_or_d=1; in MEM_WRITE, mem_write=1 and i_or_d=1; both held for the whole wait.
REQ-018 SHALL, in MEM_WB, drive reg_write=1, mem_to_reg=1, reg_dst=0; in R_WB, reg_write=1, reg_dst=1, mem_to_reg=0.
REQ-019 SHALL, in R_EXEC, drive alu_src_a=1, alu_src_b=00, alu_op=10.
REQ-020 SHALL, in BRANCH, drive alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_source=01; in JUMP, pc_write=1, pc_source=10.
REQ-021 SHALL drive pc_en = pc_write | (pc_write_cond & zero) in every state.
REQ-022 SHALL increment retired by 1, modulo 2^CNT_W (all-ones wraps to 0), on each edge leaving MEM_WB, R_WB, BRANCH, JUMP, or MEM_WRITE with mem_ready=1.
REQ-023 SHALL NOT increment retired for illegal opcodes or for wait cycles.
REQ-024 SHALL ignore mem_ready in every state except FETCH, MEM_READ and MEM_WRITE.

Reset
REQ-025 SHALL, while rst_n=0, immediately force state=FETCH and retired=0, regardless of clk; in-flight instructions are abandoned.
REQ-026 SHALL produce outputs during reset that are the FETCH values of REQ-014 (mem_read=1, alu_src_b=01, ir_write=pc_write=mem_ready).
REQ-027 SHALL, on the first rising edge after rst_n deasserts, evaluate FETCH normally.

Verification
REQ-028 SHALL pass: lw with mem_ready always 1 -> states 0,1,2,3,4,0; five cycles; reg_write=mem_to_reg=1 in state 4; retired 0->1.
REQ-029 SHALL pass: sw with mem_ready low for 3 cycles in MEM_WRITE -> state stays 5 for 4 cycles with mem_write=1; retired increments once, on the exit edge.
REQ-030 SHALL pass: beq with zero=1, then with zero=0 -> pc_en=1 in state 8 for the first and pc_en=0 for the second; alu_op=01; each retires in 3 cycles.
REQ-031 SHALL pass: add (R-type) then j -> states 0,1,6,7,0,1,9,0; alu_op=10 in state 6; pc_source=10 and pc_en=1 in state 9; retired=2.
REQ-032 SHALL pass: opcode 111111 -> illegal_op=1 for one cycle in DECODE, then FETCH; retired unchanged.
REQ-033 SHALL pass: rst_n pulsed low mid-cycle during MEM_READ -> state=0 and retired=0 before the next edge; with CNT_W=4, 16 retires after preload 15 wrap retired to 15 (all-ones->0 on the first retire).
